// File: rtl/smc_seq.sv
// smc_seq: streamed per-channel MOSFET current/gm calculator with top-K / bottom-K frame aggregation.
// Optional macro SMC_SEQ_FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module smc_seq #(
    parameter int N_CH   = 6,
    parameter int K_SEL  = 3,
    parameter int W_BITS = 3,
    parameter int V_BITS = 3,
    parameter int OUT_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [W_BITS-1:0]   w,
    input  logic [V_BITS-1:0]   v_gs,
    input  logic [V_BITS-1:0]   v_ds,
    output logic                out_valid,
    output logic [OUT_W-1:0]    out_n,
`ifdef SMC_SEQ_FRAME_CNT_EN
    output logic [15:0]         frame_cnt,
`endif
    output logic [2:0]          o_dbg_state
);

    localparam int VAL_W = W_BITS + 2*V_BITS + 2;
    localparam int SUM_W = VAL_W + $clog2(K_SEL + 1);
    localparam int EXT_W = SUM_W + OUT_W;
    localparam int CNT_W = $clog2(N_CH + 1);
    localparam logic [EXT_W-1:0] OUT_MAX = {{SUM_W{1'b0}}, {OUT_W{1'b1}}};

    // Handshake: a beat is taken on a rising edge where in_valid && in_ready;
    // beats offered while in_ready=0 are dropped, and in_valid may gap mid-frame.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DRAIN1 = 3'd2,
        S_DRAIN2 = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_mode;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_n;
    logic [15:0]         r_frame_cnt;

    logic                r_s1_vld;
    logic [VAL_W-1:0]    r_s1_val;
    logic [VAL_W-1:0]    r_list [K_SEL];
    logic [K_SEL-1:0]    r_lvld;

    logic                w_accept;
    logic [1:0]          w_mode_eff;
    logic [VAL_W-1:0]    w_w_ext, w_vov_ext, w_vds_ext;
    logic                w_cutoff, w_triode;
    logic [VAL_W-1:0]    w_i_tri, w_i_sat, w_g_tri, w_g_sat, w_num, w_val;
    logic [K_SEL-1:0]    w_ins;
    logic [VAL_W-1:0]    w_nlist [K_SEL];
    logic [K_SEL-1:0]    w_nvld;
    logic [SUM_W-1:0]    w_sum, w_res;
    logic [EXT_W-1:0]    w_res_ext;
    logic [OUT_W-1:0]    w_out;

    assign w_accept   = in_valid && r_in_ready;
    // mode is only latched on the first beat, so that beat must see the live input
    assign w_mode_eff = (r_state == S_IDLE) ? mode : r_mode;

    assign w_w_ext   = VAL_W'(w);
    assign w_vov_ext = VAL_W'(v_gs - V_BITS'(1));
    assign w_vds_ext = VAL_W'(v_ds);
    assign w_cutoff  = (v_gs <= V_BITS'(1));
    assign w_triode  = (w_vov_ext > w_vds_ext);

    assign w_i_tri = w_w_ext * (((w_vov_ext * w_vds_ext) << 1) - (w_vds_ext * w_vds_ext));
    assign w_i_sat = w_w_ext * w_vov_ext * w_vov_ext;
    assign w_g_tri = (w_w_ext * w_vds_ext) << 1;
    assign w_g_sat = (w_w_ext * w_vov_ext) << 1;
    assign w_num   = w_mode_eff[0] ? (w_triode ? w_i_tri : w_i_sat)
                                   : (w_triode ? w_g_tri : w_g_sat);
    assign w_val   = w_cutoff ? '0 : (w_num / VAL_W'(3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_val <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) r_s1_val <= w_val;
        end
    end

    // Sorted insert: strict compare keeps an earlier equal value ahead of a newcomer.
    always_comb begin
        for (int i = 0; i < K_SEL; i++) begin
            w_ins[i] = !r_lvld[i] ||
                       (r_mode[1] ? (r_s1_val > r_list[i]) : (r_s1_val < r_list[i]));
        end
        w_nlist[0] = w_ins[0] ? r_s1_val : r_list[0];
        w_nvld[0]  = 1'b1;
        for (int i = 1; i < K_SEL; i++) begin
            w_nlist[i] = !w_ins[i] ? r_list[i] : (w_ins[i-1] ? r_list[i-1] : r_s1_val);
            w_nvld[i]  = r_lvld[i] | r_lvld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == S_OUT) begin
            for (int i = 0; i < K_SEL; i++) r_list[i] <= '0;
            r_lvld <= '0;
        end else if (r_s1_vld) begin
            for (int i = 0; i < K_SEL; i++) r_list[i] <= w_nlist[i];
            r_lvld <= w_nvld;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < K_SEL; i++) w_sum = w_sum + SUM_W'(r_list[i]);
        w_res     = r_mode[0] ? (w_sum / SUM_W'(K_SEL)) : w_sum;
        w_res_ext = EXT_W'(w_res);
        w_out     = (w_res_ext > OUT_MAX) ? {OUT_W{1'b1}} : w_res_ext[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mode      <= 2'b00;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_n     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode <= mode;
                        r_cnt  <= CNT_W'(1);
                        if (N_CH == 1) begin
                            r_state    <= S_DRAIN1;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(N_CH - 1)) begin
                            r_state    <= S_DRAIN1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN1: r_state <= S_DRAIN2;
                S_DRAIN2: begin
                    r_state     <= S_OUT;
                    r_out_valid <= 1'b1;
                    r_out_n     <= w_out;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                S_OUT: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_n       = r_out_n;
    assign o_dbg_state = r_state;
`ifdef SMC_SEQ_FRAME_CNT_EN
    assign frame_cnt   = r_frame_cnt;
`endif

endmodule

// File: tb/tb_smc_seq.sv
// Directed + randomized bench for smc_seq against a sort-based frame reference model.
module tb_smc_seq;
  localparam int N_CH   = 6;
  localparam int K_SEL  = 3;
  localparam int W_BITS = 3;
  localparam int V_BITS = 3;
  localparam int OUT_W  = 10;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid;
  logic [1:0] mode;
  logic [W_BITS-1:0] w;
  logic [V_BITS-1:0] v_gs, v_ds;
  logic [OUT_W-1:0] out_n;
  logic [2:0] dbg_state;
`ifdef SMC_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_assert = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int n_frames = 0;
  int n_frames_since_rst = 0;
  logic [OUT_W-1:0] exp_q[$];

  int ramp[N_CH] = '{1, 2, 3, 4, 5, 6};
  int all7[N_CH] = '{7, 7, 7, 7, 7, 7};
  int all4[N_CH] = '{4, 4, 4, 4, 4, 4};
  int all3[N_CH] = '{3, 3, 3, 3, 3, 3};

  smc_seq #(
    .N_CH(N_CH), .K_SEL(K_SEL), .W_BITS(W_BITS), .V_BITS(V_BITS), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .w(w),
    .v_gs(v_gs),
    .v_ds(v_ds),
    .out_valid(out_valid),
    .out_n(out_n),
`ifdef SMC_SEQ_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / pulse monitor
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid === 1'b1) n_pulse++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: device equations, then sort and pick the K extremes
  function automatic int model_val(int wi, int g, int d, bit cur);
    int vov;
    if (g <= 1) return 0;
    vov = g - 1;
    if (vov > d) return cur ? (wi * (2 * vov * d - d * d)) / 3 : (2 * wi * d) / 3;
    return cur ? (wi * vov * vov) / 3 : (2 * wi * vov) / 3;
  endfunction

  function automatic int model_frame(input int wv[N_CH], input int gv[N_CH],
                                     input int dv[N_CH], input logic [1:0] md);
    int q[$];
    int sum;
    int res;
    for (int i = 0; i < N_CH; i++) q.push_back(model_val(wv[i], gv[i], dv[i], md[0]));
    q.sort();
    sum = 0;
    for (int k = 0; k < K_SEL; k++) sum += md[1] ? q[N_CH - 1 - k] : q[k];
    res = md[0] ? sum / K_SEL : sum;
    if (res > (1 << OUT_W) - 1) res = (1 << OUT_W) - 1;
    return res;
  endfunction

  // driver: caller sits 1 time unit after a rising edge
  task automatic run_frame(input int wv[N_CH], input int gv[N_CH], input int dv[N_CH],
                           input logic [1:0] md, input int gap, input bit hold,
                           input string tag);
    int guard;
    int lat;
    logic [OUT_W-1:0] exp;
    exp_q.push_back(OUT_W'(model_frame(wv, gv, dv, md)));
    for (int i = 0; i < N_CH; i++) begin
      if (i > 0) for (int g = 0; g < gap; g++) begin in_valid = 1'b0; step(); end
      in_valid = 1'b1;
      w    = W_BITS'(wv[i]);
      v_gs = V_BITS'(gv[i]);
      v_ds = V_BITS'(dv[i]);
      mode = (i == 0) ? md : 2'($urandom_range(0, 3));
      guard = 0;
      while (!in_ready && guard < 20) begin step(); guard++; end
      step();
      if (!(hold && i == N_CH - 1)) in_valid = 1'b0;
    end
    if (hold) begin
      w    = W_BITS'($urandom_range(0, 7));
      v_gs = V_BITS'($urandom_range(0, 7));
      v_ds = V_BITS'($urandom_range(0, 7));
    end
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      if (out_valid === 1'b1) begin lat = k; break; end
      if (k <= 2) chk({tag, " drain_in_ready"}, 32'(in_ready), 32'd0);
      step();
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " out_in_ready"}, 32'(in_ready), 32'd0);
    exp = exp_q.pop_front();
    chk({tag, " out_n"}, 32'(out_n), 32'(exp));
    step();
    in_valid = 1'b0;
    chk({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    chk({tag, " ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, " out_n_hold"}, 32'(out_n), 32'(exp));
    n_frames++;
    n_frames_since_rst++;
  endtask

  initial begin : main
    int cut_g[N_CH];
    int rw[N_CH];
    int rg[N_CH];
    int rd[N_CH];
    int p0;
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 2'b00;
    w = '0;
    v_gs = '0;
    v_ds = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_n", 32'(out_n), 32'd0);
    rst = 1'b0;
    step();

    run_frame(all7, all7, all7, 2'b11, 0, 1'b0, "sat_i_top");
    run_frame(all7, all7, all7, 2'b10, 0, 1'b0, "sat_gm_top");
    run_frame(all7, all7, all7, 2'b00, 0, 1'b0, "sat_gm_bot");
    run_frame(ramp, all4, all3, 2'b11, 0, 1'b0, "ramp_top");
    run_frame(ramp, all4, all3, 2'b01, 0, 1'b0, "ramp_bot");
    for (int i = 0; i < N_CH; i++) cut_g[i] = $urandom_range(0, 1);
    run_frame(all7, cut_g, all7, 2'($urandom_range(0, 3)), 1, 1'b0, "cutoff");
    run_frame(ramp, all4, all3, 2'b11, 0, 1'b0, "pre_rst");

    // abort a frame after three beats
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; w = 3'd7; v_gs = 3'd7; v_ds = 3'd7; mode = 2'b11;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_frames_since_rst = 0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_n", 32'(out_n), 32'd0);
    p0 = n_pulse;
    repeat (6) step();
    chk("midrst no_pulse", n_pulse - p0, 0);
    run_frame(ramp, all4, all3, 2'b11, 0, 1'b0, "post_rst");
`ifdef SMC_SEQ_FRAME_CNT_EN
    chk("frame_cnt post_rst", 32'(frame_cnt), 32'd1);
`endif

    run_frame(ramp, all4, all3, 2'b11, 2, 1'b1, "gap_hold");

    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < N_CH; i++) begin
        rw[i] = $urandom_range(0, 7);
        rg[i] = $urandom_range(0, 7);
        rd[i] = $urandom_range(0, 7);
      end
      run_frame(rw, rg, rd, 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), "random");
    end

    repeat (3) step();
    chk("total pulses", n_pulse, n_frames);
    chk("queue empty", exp_q.size(), 0);
`ifdef SMC_SEQ_FRAME_CNT_EN
    chk("frame_cnt final", 32'(frame_cnt), 32'(n_frames_since_rst));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
